// File: rtl/screen_fetch_pkg.sv
// screen_fetch_pkg
//   Shared definitions for the pipelined screen-RAM pixel fetch:
//   - ppw():           pixels per screen-RAM word
//   - pipe_lat():      input-to-colour latency in clocks
//   - pipe_flags_t:    per-stage valid / in-window flags
//   - default_color(): reset palette (16-entry RGB444 table; narrower
//                      palettes use the first 2^PIX_BITS entries)
package screen_fetch_pkg;

  function automatic int ppw(input int data_width, input int pix_bits);
    return data_width / pix_bits;
  endfunction

  // One stage to register the inputs, one for the RAM request, then the
  // RAM latency, then the registered colour.
  function automatic int pipe_lat(input int ram_latency);
    return 2 + ram_latency;
  endfunction

  typedef struct packed {
    logic valid;   // the pixel had pix_de=1
    logic in_win;  // the pixel lies inside the active window
  } pipe_flags_t;

  function automatic logic [11:0] default_color(input int idx);
    logic [11:0] c;
    case (idx)
      0:       c = 12'h000;
      1:       c = 12'h00A;
      2:       c = 12'h0A0;
      3:       c = 12'h0AA;
      4:       c = 12'hA00;
      5:       c = 12'hA0A;
      6:       c = 12'hA50;
      7:       c = 12'hAAA;
      8:       c = 12'h555;
      9:       c = 12'h55F;
      10:      c = 12'h5F5;
      11:      c = 12'h5FF;
      12:      c = 12'hF55;
      13:      c = 12'hF5F;
      14:      c = 12'hFF5;
      15:      c = 12'hFFF;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/screen_pixel_fetch_palette.sv
// pixel_palette
//   2^PIX_BITS x 12-bit register file, one write port, one asynchronous
//   read port. Reset loads the default palette.
//   clk, rst        : clock, synchronous active-high reset
//   we/waddr/wdata  : write strobe, entry, RGB444 value (written at the edge)
//   raddr/rdata     : lookup entry and its current value
//   A read of an entry being written in the same cycle returns the old value.
module pixel_palette
  import screen_fetch_pkg::*;
#(
  parameter int PIX_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [PIX_BITS-1:0] waddr,
  input  logic [11:0]         wdata,
  input  logic [PIX_BITS-1:0] raddr,
  output logic [11:0]         rdata
);

  localparam int ENTRIES = 1 << PIX_BITS;

  logic [11:0] regs [ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) regs[i] <= default_color(i);
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = regs[raddr];

endmodule

// File: rtl/screen_pixel_fetch.sv
// screen_pixel_fetch
//   Turns the VGA pixel coordinate stream into screen-RAM word reads and
//   RGB444 colours with a fixed latency of 2+RAM_LATENCY clocks.
//   clk, rst                 : clock, synchronous active-high reset
//   pix_x/pix_y/pix_de       : coordinate stream and display enable
//   frame_start              : loads the active window from win_*
//   win_x/win_y/win_w/win_h  : requested window (shadowed per frame)
//   pal_we/pal_addr/pal_data : palette write port
//   ram_addr/ram_re          : word read request (issued only on address change)
//   ram_data                 : read data, RAM_LATENCY clocks after ram_re
//   color/color_valid        : output pixel; valid marks pix_de=1 inputs
module screen_pixel_fetch
  import screen_fetch_pkg::*;
#(
  parameter int                    SCREEN_WIDTH = 11,
  parameter int                    ADDR_WIDTH   = 25,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    PIX_BITS     = 4,
  parameter int                    RAM_LATENCY  = 1,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR   = '0,
  parameter int                    DEF_WX       = 76,
  parameter int                    DEF_WY       = 100,
  parameter int                    DEF_WW       = 488,
  parameter int                    DEF_WH       = 280,
  parameter logic [11:0]           BORDER_COLOR = 12'h000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SCREEN_WIDTH-1:0] pix_x,
  input  logic [SCREEN_WIDTH-1:0] pix_y,
  input  logic                    pix_de,
  input  logic                    frame_start,
  input  logic [SCREEN_WIDTH-1:0] win_x,
  input  logic [SCREEN_WIDTH-1:0] win_y,
  input  logic [SCREEN_WIDTH-1:0] win_w,
  input  logic [SCREEN_WIDTH-1:0] win_h,
  input  logic                    pal_we,
  input  logic [PIX_BITS-1:0]     pal_addr,
  input  logic [11:0]             pal_data,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic                    ram_re,
  input  logic [DATA_WIDTH-1:0]   ram_data,
  output logic [11:0]             color,
  output logic                    color_valid
);

  localparam int SW  = SCREEN_WIDTH;
  localparam int LW  = 2 * SCREEN_WIDTH;
  localparam int PPW = ppw(DATA_WIDTH, PIX_BITS);
  localparam int KW  = $clog2(PPW);
  localparam int DL  = pipe_lat(RAM_LATENCY) - 2;  // stages spanning the RAM

  // Stage 1: registered inputs and active window
  logic [SW-1:0] s1_x, s1_y;
  logic          s1_de;
  logic [SW-1:0] wx, wy, ww, wh;

  // Stage 1 combinational address generation
  logic            x_in, y_in, in_win, need_re;
  logic [SW-1:0]   rx, ry;
  logic [LW-1:0]   lin;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [KW-1:0]   sub_k;
  logic            last_valid;

  // Stage 2 and RAM-latency delay line
  pipe_flags_t     s2_flags;
  logic [KW-1:0]   s2_k;
  pipe_flags_t     flags_d [DL];
  logic            re_d    [DL];
  logic [KW-1:0]   k_d     [DL];

  // Final stage
  logic [DATA_WIDTH-1:0] hold_word, fin_word;
  logic [PIX_BITS-1:0]   pal_raddr;
  logic [11:0]           pal_rdata;

  // Extra top bit keeps wx+ww from wrapping near the coordinate limit.
  assign x_in   = ({1'b0, s1_x} >= {1'b0, wx}) && ({1'b0, s1_x} < ({1'b0, wx} + {1'b0, ww}));
  assign y_in   = ({1'b0, s1_y} >= {1'b0, wy}) && ({1'b0, s1_y} < ({1'b0, wy} + {1'b0, wh}));
  assign in_win = s1_de && x_in && y_in;

  assign rx        = s1_x - wx;
  assign ry        = s1_y - wy;
  assign lin       = LW'(ry) * LW'(ww) + LW'(rx);
  assign word_addr = START_ADDR + ADDR_WIDTH'(lin >> KW);
  assign sub_k     = lin[KW-1:0];

  // ram_addr doubles as the last-issued address.
  assign need_re = in_win && (!last_valid || (word_addr != ram_addr));

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_x       <= '0;
      s1_y       <= '0;
      s1_de      <= 1'b0;
      wx         <= SW'(DEF_WX);
      wy         <= SW'(DEF_WY);
      ww         <= SW'(DEF_WW);
      wh         <= SW'(DEF_WH);
      ram_re     <= 1'b0;
      ram_addr   <= '0;
      last_valid <= 1'b0;
      s2_flags   <= '0;
      s2_k       <= '0;
    end else begin
      s1_x  <= pix_x;
      s1_y  <= pix_y;
      s1_de <= pix_de;
      if (frame_start) begin
        wx <= win_x;
        wy <= win_y;
        ww <= win_w;
        wh <= win_h;
      end
      ram_re <= need_re;
      if (need_re) ram_addr <= word_addr;
      if (frame_start)  last_valid <= 1'b0;
      else if (need_re) last_valid <= 1'b1;
      else if (!in_win) last_valid <= 1'b0;
      s2_flags.valid  <= s1_de;
      s2_flags.in_win <= in_win;
      s2_k            <= sub_k;
    end
  end

  // Carry pixel flags alongside the outstanding read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DL; i++) begin
        flags_d[i] <= '0;
        re_d[i]    <= 1'b0;
        k_d[i]     <= '0;
      end
    end else begin
      flags_d[0] <= s2_flags;
      re_d[0]    <= ram_re;
      k_d[0]     <= s2_k;
      for (int i = 1; i < DL; i++) begin
        flags_d[i] <= flags_d[i-1];
        re_d[i]    <= re_d[i-1];
        k_d[i]     <= k_d[i-1];
      end
    end
  end

  // Reads complete in order, so a pixel without its own read uses the
  // most recently returned word.
  assign fin_word = re_d[DL-1] ? ram_data : hold_word;

  always_comb begin
    pal_raddr = '0;
    for (int i = 0; i < PPW; i++) begin
      if (k_d[DL-1] == KW'(i)) pal_raddr = fin_word[i*PIX_BITS +: PIX_BITS];
    end
  end

  pixel_palette #(
    .PIX_BITS (PIX_BITS)
  ) u_palette (
    .clk   (clk),
    .rst   (rst),
    .we    (pal_we),
    .waddr (pal_addr),
    .wdata (pal_data),
    .raddr (pal_raddr),
    .rdata (pal_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_word   <= '0;
      color       <= '0;
      color_valid <= 1'b0;
    end else begin
      if (re_d[DL-1]) hold_word <= ram_data;
      color_valid <= flags_d[DL-1].valid;
      if (!flags_d[DL-1].valid)      color <= '0;
      else if (flags_d[DL-1].in_win) color <= pal_rdata;
      else                           color <= BORDER_COLOR;
    end
  end

endmodule

// File: tb/tb_screen_pixel_fetch.sv
module tb_screen_pixel_fetch;

  localparam int SW   = 11;
  localparam int AW   = 25;
  localparam int DW   = 32;
  localparam int LAT0 = 3;  // PIX_BITS=4, RAM_LATENCY=1
  localparam int LAT2 = 5;  // PIX_BITS=2, RAM_LATENCY=3

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [SW-1:0] pix_x, pix_y, win_x, win_y, win_w, win_h;
  logic          pix_de, frame_start;
  logic          pal_we;
  logic [3:0]    pal_addr;
  logic [11:0]   pal_data;
  logic          pal_we2   = 1'b0;
  logic [1:0]    pal_addr2 = 2'd0;
  logic [11:0]   pal_data2 = 12'h000;

  logic [AW-1:0] ram_addr0, ram_addr2;
  logic          ram_re0, ram_re2;
  logic [DW-1:0] ram_data0, ram_data2;
  logic [11:0]   color0, color2;
  logic          color_valid0, color_valid2;

  screen_pixel_fetch #(
    .BORDER_COLOR (12'h123)
  ) dut (
    .clk (clk), .rst (rst),
    .pix_x (pix_x), .pix_y (pix_y), .pix_de (pix_de), .frame_start (frame_start),
    .win_x (win_x), .win_y (win_y), .win_w (win_w), .win_h (win_h),
    .pal_we (pal_we), .pal_addr (pal_addr), .pal_data (pal_data),
    .ram_addr (ram_addr0), .ram_re (ram_re0), .ram_data (ram_data0),
    .color (color0), .color_valid (color_valid0)
  );

  screen_pixel_fetch #(
    .PIX_BITS    (2),
    .RAM_LATENCY (3)
  ) dut2 (
    .clk (clk), .rst (rst),
    .pix_x (pix_x), .pix_y (pix_y), .pix_de (pix_de), .frame_start (frame_start),
    .win_x (win_x), .win_y (win_y), .win_w (win_w), .win_h (win_h),
    .pal_we (pal_we2), .pal_addr (pal_addr2), .pal_data (pal_data2),
    .ram_addr (ram_addr2), .ram_re (ram_re2), .ram_data (ram_data2),
    .color (color2), .color_valid (color_valid2)
  );

  // ---------------- screen RAM models ----------------
  function automatic logic [31:0] mem(input logic [AW-1:0] a);
    if (a == 0) return 32'h76543210;
    if (a == 1) return 32'hFEDCBA98;
    return {8{a[3:0]}};
  endfunction

  logic          r0_re = 1'b0;
  logic [AW-1:0] r0_a  = '0;
  logic          r2_re [3] = '{1'b0, 1'b0, 1'b0};
  logic [AW-1:0] r2_a  [3] = '{'0, '0, '0};

  always @(posedge clk) begin
    r0_re <= ram_re0;
    r0_a  <= ram_addr0;
    r2_re[0] <= ram_re2;
    r2_a[0]  <= ram_addr2;
    for (int i = 1; i < 3; i++) begin
      r2_re[i] <= r2_re[i-1];
      r2_a[i]  <= r2_a[i-1];
    end
  end

  // Junk when no read is pending, so a missing hold register shows up.
  assign ram_data0 = r0_re    ? mem(r0_a)    : 32'hDEADBEEF;
  assign ram_data2 = r2_re[2] ? mem(r2_a[2]) : 32'hDEADBEEF;

  // ---------------- scoreboard ----------------
  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;
  logic [44:0] exp_q0[$];  // {due cycle, color_valid, color} for dut
  logic [44:0] exp_q2[$];  // same for dut2
  logic [57:0] re_q0[$];   // {due cycle, ram_re, ram_addr} for dut

  logic [11:0] pal16 [16] = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A,
                              12'hA50, 12'hAAA, 12'h555, 12'h55F, 12'h5F5, 12'h5FF,
                              12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push0(input logic v, input logic [11:0] c);
    exp_q0.push_back({32'(cyc + 1 + LAT0), v, c});
  endtask

  task automatic push2(input logic v, input logic [11:0] c);
    exp_q2.push_back({32'(cyc + 1 + LAT2), v, c});
  endtask

  task automatic push_re(input logic re, input int addr);
    re_q0.push_back({32'(cyc + 2), re, addr[AW-1:0]});
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_pix(input int x, input int y, input logic de);
    pix_x  = x[SW-1:0];
    pix_y  = y[SW-1:0];
    pix_de = de;
  endtask

  task automatic set_idle();
    set_pix($urandom_range(0, 1000), $urandom_range(0, 600), 1'b0);
  endtask

  // One clock; outputs are compared on the falling edge.
  task automatic step();
    logic [44:0] e;
    logic [57:0] r;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (exp_q0.size() > 0 && exp_q0[0][44:13] == 32'(cyc)) begin
      e = exp_q0.pop_front();
      check($sformatf("color0@%0d", cyc), {19'd0, color_valid0, color0}, {19'd0, e[12:0]});
    end
    if (exp_q2.size() > 0 && exp_q2[0][44:13] == 32'(cyc)) begin
      e = exp_q2.pop_front();
      check($sformatf("color2@%0d", cyc), {19'd0, color_valid2, color2}, {19'd0, e[12:0]});
    end
    if (re_q0.size() > 0 && re_q0[0][57:26] == 32'(cyc)) begin
      r = re_q0.pop_front();
      check($sformatf("ram0@%0d", cyc), {6'd0, ram_re0, ram_addr0}, {6'd0, r[25:0]});
    end
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    set_idle();
    while ((exp_q0.size() + exp_q2.size() + re_q0.size()) > 0 && budget > 0) begin
      step();
      budget--;
    end
    n_tests++;
    if ((exp_q0.size() + exp_q2.size() + re_q0.size()) > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected outputs never seen, required 0",
               exp_q0.size() + exp_q2.size() + re_q0.size());
      exp_q0.delete();
      exp_q2.delete();
      re_q0.delete();
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int          x;
    int          y;
    logic        de;
    logic        re;
    int          addr;
    logic        v;
    logic [11:0] c;
  } vec_t;

  vec_t tbl [22];
  int   idx2 [16] = '{0, 0, 1, 0, 2, 0, 3, 0, 0, 1, 1, 1, 2, 1, 3, 1};
  int   re2_cnt;

  initial begin
    // default window (76,100,488,280); border 12'h123 on dut
    tbl[0]  = '{200,  50, 1'b0, 1'b0,     0, 1'b0, 12'h000};
    tbl[1]  = '{ 76, 100, 1'b1, 1'b1,     0, 1'b1, 12'h000};
    tbl[2]  = '{ 77, 100, 1'b1, 1'b0,     0, 1'b1, 12'h00A};
    tbl[3]  = '{ 78, 100, 1'b1, 1'b0,     0, 1'b1, 12'h0A0};
    tbl[4]  = '{ 79, 100, 1'b1, 1'b0,     0, 1'b1, 12'h0AA};
    tbl[5]  = '{ 80, 100, 1'b1, 1'b0,     0, 1'b1, 12'hA00};
    tbl[6]  = '{ 81, 100, 1'b1, 1'b0,     0, 1'b1, 12'hA0A};
    tbl[7]  = '{ 82, 100, 1'b1, 1'b0,     0, 1'b1, 12'hA50};
    tbl[8]  = '{ 83, 100, 1'b1, 1'b0,     0, 1'b1, 12'hAAA};
    tbl[9]  = '{ 84, 100, 1'b1, 1'b1,     1, 1'b1, 12'h555};
    tbl[10] = '{ 85, 100, 1'b1, 1'b0,     1, 1'b1, 12'h55F};
    tbl[11] = '{ 75, 100, 1'b1, 1'b0,     1, 1'b1, 12'h123};
    tbl[12] = '{564, 100, 1'b1, 1'b0,     1, 1'b1, 12'h123};
    tbl[13] = '{563, 100, 1'b1, 1'b1,    60, 1'b1, 12'hF55};
    tbl[14] = '{300,  50, 1'b0, 1'b0,    60, 1'b0, 12'h000};
    tbl[15] = '{ 76, 101, 1'b1, 1'b1,    61, 1'b1, 12'hF5F};
    tbl[16] = '{ 83, 379, 1'b1, 1'b1, 17019, 1'b1, 12'h5FF};
    tbl[17] = '{ 76,  99, 1'b1, 1'b0, 17019, 1'b1, 12'h123};
    tbl[18] = '{ 76, 380, 1'b1, 1'b0, 17019, 1'b1, 12'h123};
    tbl[19] = '{ 76, 379, 1'b1, 1'b1, 17019, 1'b1, 12'h5FF};
    tbl[20] = '{ 77, 379, 1'b1, 1'b0, 17019, 1'b1, 12'h5FF};
    tbl[21] = '{ 83, 379, 1'b1, 1'b0, 17019, 1'b1, 12'h5FF};

    rst = 1'b1;
    frame_start = 1'b0;
    win_x = 11'd76; win_y = 11'd100; win_w = 11'd488; win_h = 11'd280;
    pal_we = 1'b0; pal_addr = 4'd0; pal_data = 12'h000;
    set_idle();
    step();
    step();
    check("rst_ram_re", ram_re0, 0);
    check("rst_ram_addr", ram_addr0, 0);
    check("rst_color", color0, 0);
    check("rst_color_valid", color_valid0, 0);
    check("rst_color_valid2", color_valid2, 0);
    rst = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;

    // table-driven vectors
    for (int i = 0; i < 22; i++) begin
      set_pix(tbl[i].x, tbl[i].y, tbl[i].de);
      push_re(tbl[i].re, tbl[i].addr);
      push0(tbl[i].v, tbl[i].c);
      step();
    end
    drain();

    // window shadow: mid-frame win_x write is ignored until frame_start
    win_x = 11'd0;
    set_idle(); step();
    set_pix(76, 101, 1'b1); push_re(1'b1, 61); push0(1'b1, 12'hF5F); step();
    set_idle(); frame_start = 1'b1; push_re(1'b0, 61); push0(1'b0, 12'h000); step();
    frame_start = 1'b0;
    set_pix(0, 100, 1'b1);   push_re(1'b1, 0);  push0(1'b1, 12'h000); step();
    set_pix(7, 100, 1'b1);   push_re(1'b0, 0);  push0(1'b1, 12'hAAA); step();
    set_pix(487, 100, 1'b1); push_re(1'b1, 60); push0(1'b1, 12'hF55); step();
    set_pix(563, 100, 1'b1); push_re(1'b0, 60); push0(1'b1, 12'h123); step();
    win_x = 11'd76;
    set_idle(); frame_start = 1'b1; step();
    frame_start = 1'b0;
    drain();

    // palette write while an index-3 pixel is in the final stage
    set_pix(79, 100, 1'b1); push_re(1'b1, 0); push0(1'b1, 12'h0AA); step();
    set_pix(79, 100, 1'b1); push_re(1'b0, 0); push0(1'b1, 12'hF0F); step();
    set_idle(); push0(1'b0, 12'h000); step();
    pal_we = 1'b1; pal_addr = 4'd3; pal_data = 12'hF0F;
    set_idle(); push0(1'b0, 12'h000); step();
    pal_we = 1'b0;
    drain();

    // 2-bit pixels, RAM latency 3: one read, LSB-first fields
    set_idle(); step();
    re2_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      set_pix(76 + i, 100, 1'b1);
      push2(1'b1, pal16[idx2[i]]);
      step();
      if (ram_re2) re2_cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      set_idle(); step();
      if (ram_re2) re2_cnt++;
    end
    check("dut2_re_count", re2_cnt, 1);
    check("dut2_ram_addr", ram_addr2, 0);
    drain();

    // reset mid-row drops in-flight pixels
    for (int i = 0; i < 4; i++) begin
      set_pix(76 + i, 100, 1'b1); step();
    end
    rst = 1'b1;
    set_pix(80, 100, 1'b1); step();
    check("mid_rst_valid0", color_valid0, 0);
    check("mid_rst_valid2", color_valid2, 0);
    check("mid_rst_color0", color0, 0);
    check("mid_rst_ram_re0", ram_re0, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_idle(); step();
      check($sformatf("post_rst_valid0_%0d", i), color_valid0, 0);
      check($sformatf("post_rst_valid2_%0d", i), color_valid2, 0);
    end

    // palette and window back at defaults after reset
    set_pix(79, 100, 1'b1); push_re(1'b1, 0); push0(1'b1, 12'h0AA); push2(1'b1, 12'h000); step();
    set_pix(80, 100, 1'b1); push_re(1'b0, 0); push0(1'b1, 12'hA00); push2(1'b1, 12'h0A0); step();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/screen_pixel_fetch.md
Name: screen_pixel_fetch

Overview:
Pipelined successor to the combinational screen-RAM pixel lookup in the VGA display path. It takes the per-clock pixel coordinate stream from the VGA timing generator and issues word reads to screen RAM. It unpacks PIX_BITS-wide colour indices from the returned words and maps them through a writable palette to 12-bit RGB. The window position and size are runtime registers, double-buffered per frame. A word read is issued only when the word address changes.

Parameters:
SCREEN_WIDTH, 11, coordinate width
ADDR_WIDTH, 25, screen-RAM word address width
DATA_WIDTH, 32, screen-RAM word width
PIX_BITS, 4, bits per colour index; legal values 1, 2, 4; PPW = DATA_WIDTH/PIX_BITS pixels per word
RAM_LATENCY, 1, cycles from ram_re to ram_data valid; legal range 1..3
START_ADDR, 0, base word address of the framebuffer
DEF_WX / DEF_WY / DEF_WW / DEF_WH, 76 / 100 / 488 / 280, reset window x-start, y-start, width, height
BORDER_COLOR, 12'h000, colour output outside the window

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
pix_x  in  SCREEN_WIDTH  current pixel x
pix_y  in  SCREEN_WIDTH  current pixel y
pix_de  in  1  display-enable (visible pixel)
frame_start  in  1  one-cycle pulse before the first pixel of a frame
win_x, win_y, win_w, win_h  in  SCREEN_WIDTH each  requested window; shadowed at frame_start
pal_we  in  1  palette write strobe
pal_addr  in  PIX_BITS  palette entry
pal_data  in  12  RGB444 value
ram_addr  out  ADDR_WIDTH  word address
ram_re  out  1  read strobe
ram_data  in  DATA_WIDTH  read data, valid RAM_LATENCY cycles after ram_re
color  out  12  RGB444 pixel
color_valid  out  1  color corresponds to a pix_de=1 input

Behaviour:
- Reset (rst=1 at a clk edge):
  - ram_re=0, ram_addr=0, color=0, color_valid=0.
  - Active window := DEF_*.
  - Palette := default table from the package.
  - Last-issued-address flag cleared.
  - Word hold register := 0.
  - All pipeline valid bits := 0.
  - Reset mid-frame drops all in-flight pixels; no output until new inputs traverse the pipe.
- Window shadow:
  - Active window registers load win_* on the cycle frame_start=1.
  - At all other times the active window is unchanged; mid-frame writes never tear.
- Fixed latency:
  - Input sampled at edge t produces ram_addr/ram_re at t+1.
  - color/color_valid appear at t+2+RAM_LATENCY.
  - Latency is constant for every pixel: in-window, border, or pix_de=0.
  - color_valid=1 iff pix_de was 1; pix_de=0 gives color=0, color_valid=0.
- In-window test: wx <= x < wx+ww and wy <= y < wy+wh. Compare at SCREEN_WIDTH+1 bits so the sum cannot wrap.
- Address arithmetic:
  - rx = x-wx, ry = y-wy.
  - lin = ry*ww + rx, computed at 2*SCREEN_WIDTH bits.
  - word = START_ADDR + lin/PPW, truncated to ADDR_WIDTH.
  - Sub-index k = lin mod PPW.
  - Index = ram_data bits [k*PIX_BITS +: PIX_BITS]: LSB-first; pixel 0 of a word is the lowest field.
- Read suppression:
  - ram_re=1 only for in-window pixels whose word differs from the last issued address, or when the last-issued flag is clear.
  - The flag is cleared by reset, by frame_start, and by any out-of-window or pix_de=0 pixel.
  - If ram_re=1, the word hold register captures ram_data RAM_LATENCY cycles later.
  - If ram_re=0, the final stage uses the hold register. This is correct because reads are in order.
  - ram_addr holds its last value when ram_re=0.
- Output stage:
  - In-window: color = palette[index].
  - Out of window with pix_de=1: color = BORDER_COLOR.
- Palette:
  - pal_we writes at the edge.
  - A lookup in the same cycle as a write to the same entry returns the old value; the new value is seen from the next cycle.

Decomposition:
- Package screen_fetch_pkg holds:
  - PPW function.
  - Default 16-entry RGB444 palette (the existing ColorCvt mapping; truncated for PIX_BITS<4).
  - Pipeline valid/in-window flag struct.
  - LAT = 2+RAM_LATENCY.
- Sub-module pixel_palette: a 2^PIX_BITS × 12 register file with one write port and one read port, reset to the default palette.

Test Plan:
- Reset, defaults, RAM returns 32'h76543210 for word 0, row y=100 x=76..83 -> ram_re once at addr 0; colors = palette[0..7] in order; first color_valid at cycle 3 after the input (RAM_LATENCY=1).
- Pixel (75,100) and (564,100), pix_de=1 -> ram_re=0, color=BORDER_COLOR, color_valid=1; pix_de=0 anywhere -> color_valid=0.
- Pixel (76,101) -> ram_addr = 488/8 = 61; (83,379) -> (279*488+7)>>3 = 17019.
- win_x changed to 0 mid-frame, then frame_start pulsed -> addresses unchanged until frame_start, x=0 maps to addr 0 afterwards.
- pal_we entry 3 := 12'hF0F while pixel index 3 is in the final stage -> that pixel shows the old value, the next index-3 pixel shows F0F.
- PIX_BITS=2, RAM_LATENCY=3, 16 consecutive in-window pixels -> exactly one ram_re, latency 5, fields taken LSB-first; rst asserted mid-row -> color_valid=0 the next cycle.
